// File: rtl/pipe_addsub.sv
// pipe_addsub -- segmented, pipelined two's-complement adder/subtractor.
//
// The WIDTH-bit operation is split into NSEG = WIDTH/SEG_W carry-chain
// segments. Stage k adds segment k-1 of A and B' together with the registered
// carry from stage k-1, so no carry ripples across a register boundary.
// Operands still to be summed and completed result segments travel alongside
// the partial sums. When SAT_EN=1, one more stage clamps signed overflow to the
// most positive or most negative value.
//
// Latency is NSEG cycles with SAT_EN=0 and NSEG+1 cycles with SAT_EN=1. The
// block accepts one op per clock, has no backpressure, and returns results in
// order.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high; clears every stage
//   in_valid   operands and mode are valid this cycle
//   sub        0: A+B, 1: A-B (sampled with in_valid)
//   in_a       operand A, WIDTH bits
//   in_b       operand B, WIDTH bits
//   out_valid  one-cycle pulse per completed op
//   rslt       result; holds its last value while out_valid=0
//   carry_out  carry out of the MSB (sub: 1 = no borrow)
//   ovf        signed overflow of the unsaturated result
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int SEG_W  = 16,
  parameter int SAT_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] rslt,
  output logic             carry_out,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;

  generate
    if (WIDTH % SEG_W != 0) begin : g_width_check
      $error("pipe_addsub: WIDTH (%0d) must be a multiple of SEG_W (%0d)", WIDTH, SEG_W);
    end
  endgenerate

  // Clamp to the extreme value with the sign of A. On signed overflow, A and
  // B' share the same sign, and the true result lies beyond that end of the
  // range.
  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] sum,
    input logic                    ovf_in,
    input logic                    a_msb
  );
    if (!ovf_in) begin
      return sum;
    end else if (a_msb) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end
  endfunction

  // Registered state after stage k (k = 1..NSEG).
  logic signed [WIDTH-1:0] a_p   [1:NSEG];
  logic signed [WIDTH-1:0] b_p   [1:NSEG];  // B' (already inverted for sub)
  logic signed [WIDTH-1:0] s_p   [1:NSEG];  // lower k segments of the result
  logic                    c_p   [1:NSEG];  // carry into segment k
  logic                    vld_p [1:NSEG];

  // Inputs seen by stage k+1 (k = 0..NSEG-1): the ports for k=0, otherwise
  // the registers of the preceding stage.
  logic signed [WIDTH-1:0] st_a  [0:NSEG-1];
  logic signed [WIDTH-1:0] st_b  [0:NSEG-1];
  logic signed [WIDTH-1:0] st_s  [0:NSEG-1];
  logic                    st_c  [0:NSEG-1];
  logic                    st_v  [0:NSEG-1];

  logic        [SEG_W:0]   seg_sum [0:NSEG-1];
  logic signed [WIDTH-1:0] s_nxt   [0:NSEG-1];

  genvar k;
  generate
    for (k = 0; k < NSEG; k++) begin : g_seg
      if (k == 0) begin : g_first
        // Subtraction is A + ~B + 1, with the +1 entering as the carry-in.
        assign st_a[k] = in_a;
        assign st_b[k] = sub ? ~in_b : in_b;
        assign st_s[k] = '0;
        assign st_c[k] = sub;
        assign st_v[k] = in_valid;
      end else begin : g_rest
        assign st_a[k] = a_p[k];
        assign st_b[k] = b_p[k];
        assign st_s[k] = s_p[k];
        assign st_c[k] = c_p[k];
        assign st_v[k] = vld_p[k];
      end

      assign seg_sum[k] = {1'b0, st_a[k][k*SEG_W +: SEG_W]}
                        + {1'b0, st_b[k][k*SEG_W +: SEG_W]}
                        + {{SEG_W{1'b0}}, st_c[k]};

      // Segments above k are still zero in st_s, so OR-ing inserts this one.
      assign s_nxt[k] = st_s[k] | (WIDTH'(seg_sum[k][SEG_W-1:0]) << (k*SEG_W));
    end
  endgenerate

  // ---- segment stages 1..NSEG ----
  // The data registers load only with a valid op, so bubbles leave the last
  // result in place all the way to the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= NSEG; i++) begin
        vld_p[i] <= 1'b0;
        a_p[i]   <= '0;
        b_p[i]   <= '0;
        s_p[i]   <= '0;
        c_p[i]   <= 1'b0;
      end
    end else begin
      for (int i = 1; i <= NSEG; i++) begin
        vld_p[i] <= st_v[i-1];
        if (st_v[i-1]) begin
          a_p[i] <= st_a[i-1];
          b_p[i] <= st_b[i-1];
          s_p[i] <= s_nxt[i-1];
          c_p[i] <= seg_sum[i-1][SEG_W];
        end
      end
    end
  end

  // Overflow of the wrapped sum, taken from the operand signs carried with it.
  logic signed [WIDTH-1:0] sum_w;
  logic                    ovf_w;
  logic                    a_msb_w;

  assign sum_w   = s_p[NSEG];
  assign a_msb_w = a_p[NSEG][WIDTH-1];
  assign ovf_w   = (a_msb_w == b_p[NSEG][WIDTH-1]) && (sum_w[WIDTH-1] != a_msb_w);

  generate
    if (SAT_EN != 0) begin : g_sat
      logic signed [WIDTH-1:0] rslt_ps;
      logic                    cout_ps;
      logic                    ovf_ps;
      logic                    vld_ps;

      // ---- saturation stage ----
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_ps  <= 1'b0;
          rslt_ps <= '0;
          cout_ps <= 1'b0;
          ovf_ps  <= 1'b0;
        end else begin
          vld_ps <= vld_p[NSEG];
          if (vld_p[NSEG]) begin
            rslt_ps <= saturate(sum_w, ovf_w, a_msb_w);
            cout_ps <= c_p[NSEG];
            ovf_ps  <= ovf_w;
          end
        end
      end

      assign out_valid = vld_ps;
      assign rslt      = rslt_ps;
      assign carry_out = cout_ps;
      assign ovf       = ovf_ps;
    end else begin : g_wrap
      assign out_valid = vld_p[NSEG];
      assign rslt      = sum_w;
      assign carry_out = c_p[NSEG];
      assign ovf       = ovf_w;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub. It drives four configurations from one clock:
//   d0: 32/16 wrap, d1: 32/16 saturating, d2: 48/12 wrap, d3: 8/8 wrap.
// The driver pushes hand-computed expectations into per-DUT queues. A monitor
// on the falling edge pops and compares them, and between valid outputs it
// checks the held values and the reset state.
module tb_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv [4];
  logic sv [4];
  logic [31:0] a0, b0, a1, b1;
  logic [47:0] a2, b2;
  logic [7:0]  a3, b3;

  logic ov [4];
  logic cov [4];
  logic ofv [4];
  logic [31:0] r0, r1;
  logic [47:0] r2;
  logic [7:0]  r3;
  logic [63:0] r_v [4];

  always_comb begin
    r_v[0] = {32'b0, r0};
    r_v[1] = {32'b0, r1};
    r_v[2] = {16'b0, r2};
    r_v[3] = {56'b0, r3};
  end

  pipe_addsub #(.WIDTH(32), .SEG_W(16), .SAT_EN(0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .sub(sv[0]), .in_a(a0), .in_b(b0),
    .out_valid(ov[0]), .rslt(r0), .carry_out(cov[0]), .ovf(ofv[0]));
  pipe_addsub #(.WIDTH(32), .SEG_W(16), .SAT_EN(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .sub(sv[1]), .in_a(a1), .in_b(b1),
    .out_valid(ov[1]), .rslt(r1), .carry_out(cov[1]), .ovf(ofv[1]));
  pipe_addsub #(.WIDTH(48), .SEG_W(12), .SAT_EN(0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .sub(sv[2]), .in_a(a2), .in_b(b2),
    .out_valid(ov[2]), .rslt(r2), .carry_out(cov[2]), .ovf(ofv[2]));
  pipe_addsub #(.WIDTH(8), .SEG_W(8), .SAT_EN(0)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .sub(sv[3]), .in_a(a3), .in_b(b3),
    .out_valid(ov[3]), .rslt(r3), .carry_out(cov[3]), .ovf(ofv[3]));

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  exp_t q [4][$];
  int   lat [4] = '{2, 3, 4, 1};
  int   cyc = 0;
  logic rst_seen = 1'b0;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= rst;

  // ---------------- driver ----------------
  task automatic load(input int d, input logic v, input logic s,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] er, input logic ec, input logic eo,
                      input bit keep);
    exp_t e;
    iv[d] = v;
    sv[d] = s;
    case (d)
      0: begin a0 = a[31:0]; b0 = b[31:0]; end
      1: begin a1 = a[31:0]; b1 = b[31:0]; end
      2: begin a2 = a[47:0]; b2 = b[47:0]; end
      default: begin a3 = a[7:0]; b3 = b[7:0]; end
    endcase
    if (v && keep) begin
      e.r = er;
      e.c = ec;
      e.o = eo;
      e.cyc = cyc + lat[d];
      q[d].push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) iv[i] = 1'b0;
  endtask

  task automatic issue(input int d, input logic s, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] er,
                       input logic ec, input logic eo);
    load(d, 1'b1, s, a, b, er, ec, eo, 1'b1);
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin iv[i] = 1'b0; sv[i] = 1'b0; end
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // d0: cross-segment carry, borrow, signed overflow, A-A
    issue(0, 0, 64'h0000FFFF, 64'h1,        64'h00010000, 0, 0);
    issue(0, 1, 64'h0,        64'h1,        64'hFFFFFFFF, 0, 0);
    issue(0, 1, 64'h5,        64'h3,        64'h2,        1, 0);
    issue(0, 0, 64'h7FFFFFFF, 64'h1,        64'h80000000, 0, 1);
    issue(0, 1, 64'h1234,     64'h1234,     64'h0,        1, 0);
    idle(3);

    // d0 stream: valid 1,1,0,1 with sub 0,1,x,0; junk operands in the bubble
    issue(0, 0, 64'h12345678, 64'h11111111, 64'h23456789, 0, 0);
    issue(0, 1, 64'h80000000, 64'h1,        64'h7FFFFFFF, 1, 1);
    load(0, 1'b0, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0, 0, 0, 1'b0);
    step();
    issue(0, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 1, 0);
    idle(3);

    // d1: saturating variant
    issue(1, 0, 64'h7FFFFFFF, 64'h1,        64'h7FFFFFFF, 0, 1);
    issue(1, 1, 64'h80000000, 64'h1,        64'h80000000, 1, 1);
    issue(1, 0, 64'h10,       64'h20,       64'h30,       0, 0);
    issue(1, 0, 64'h80000000, 64'h80000000, 64'h80000000, 1, 1);
    idle(4);

    // d2: ripple across four 12-bit stages
    issue(2, 0, 64'hFFFFFFFFFFFF, 64'h1, 64'h0,            1, 0);
    issue(2, 1, 64'h1000,         64'h1, 64'hFFF,          1, 0);
    issue(2, 0, 64'h7FFFFFFFFFFF, 64'h1, 64'h800000000000, 0, 1);
    idle(5);

    // d3: single segment
    issue(3, 0, 64'h7F, 64'h1, 64'h80, 0, 1);
    issue(3, 1, 64'h0,  64'h1, 64'hFF, 0, 0);
    issue(3, 0, 64'hFF, 64'h1, 64'h0,  1, 0);
    idle(2);

    // Ops in flight on d0/d1/d2 are discarded by reset; ops offered during
    // reset are ignored.
    load(2, 1'b1, 1'b0, 64'h1, 64'h1, 64'h0, 0, 0, 1'b0);
    step();
    load(2, 1'b1, 1'b0, 64'h2, 64'h2, 64'h0, 0, 0, 1'b0);
    load(1, 1'b1, 1'b0, 64'h3, 64'h3, 64'h0, 0, 0, 1'b0);
    load(0, 1'b1, 1'b1, 64'h9, 64'h4, 64'h0, 0, 0, 1'b0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 1'b1, 1'b0, 64'h55, 64'h22, 64'h0, 0, 0, 1'b0);
    step();
    rst = 1'b0;
    issue(0, 0, 64'h1, 64'h2, 64'h3, 0, 0);
    idle(6);
    done = 1'b1;
  end

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask

  initial begin
    exp_t        e;
    logic [63:0] last_r [4];
    logic        last_c [4];
    logic        last_o [4];
    bit          hold_en;
    hold_en = 1'b0;
    for (int i = 0; i < 4; i++) begin last_r[i] = '0; last_c[i] = 1'b0; last_o[i] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (rst_seen) begin
          chk("rst_out_valid", d, 64'(ov[d]),  64'h0);
          chk("rst_rslt",      d, r_v[d],      64'h0);
          chk("rst_carry",     d, 64'(cov[d]), 64'h0);
          chk("rst_ovf",       d, 64'(ofv[d]), 64'h0);
          last_r[d] = '0;
          last_c[d] = 1'b0;
          last_o[d] = 1'b0;
        end else if (ov[d] === 1'b1) begin
          if (q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: got out_valid=1 rslt=%h expected no output", d, r_v[d]);
          end else begin
            e = q[d].pop_front();
            chk("rslt",    d, r_v[d],      e.r);
            chk("carry",   d, 64'(cov[d]), 64'(e.c));
            chk("ovf",     d, 64'(ofv[d]), 64'(e.o));
            chk("latency", d, 64'(cyc),    64'(e.cyc));
            last_r[d] = e.r;
            last_c[d] = e.c;
            last_o[d] = e.o;
          end
        end else if (hold_en) begin
          chk("hold_rslt",  d, r_v[d],      last_r[d]);
          chk("hold_carry", d, 64'(cov[d]), 64'(last_c[d]));
          chk("hold_ovf",   d, 64'(ofv[d]), 64'(last_o[d]));
        end
      end
      if (rst_seen) hold_en = 1'b1;

      if (done || cyc > 2000) begin
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL watchdog: got cycle %0d expected stimulus done", cyc);
        end
        for (int d = 0; d < 4; d++) chk("queue_drained", d, 64'(q[d].size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

endmodule
